// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: shared state encoding, widths and helpers for the UART frame scheduler
package uart_sched_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_BUSY = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;
  localparam int FRAME_W = 64;
  localparam int BYTE_W  = 8;
  function automatic int max3(input int a, input int b, input int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request after ptr, with wrap
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] grant,
  output logic                 valid
);
  int idx;
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        grant = ($clog2(N))'(idx);
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_frame_scheduler.sv
// uart_frame_scheduler: round-robin frame arbiter and sequencer for the shared RS-485 UART transmitter
module uart_frame_scheduler
  import uart_sched_pkg::*;
#(
  parameter int N_SRC         = 4,
  parameter int GAP_CYCLES    = 16,
  parameter int ACK_TIMEOUT   = 64,
  parameter int FRAME_TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_SRC-1:0]           src_req,
  input  logic [64*N_SRC-1:0]        src_frame,
  output logic [N_SRC-1:0]           src_ack,
  output logic [N_SRC-1:0]           src_done,
  output logic [N_SRC-1:0]           src_err,
  output logic                       tx_rq,
  output logic [7:0]                 tx_data,
  input  logic [2:0]                 tx_switch,
  input  logic                       tx_dir_rx,
  output logic                       busy,
  output logic [$clog2(N_SRC)-1:0]   active_src
);
  localparam int SW = $clog2(N_SRC);
  localparam int TW = $clog2(max3(ACK_TIMEOUT, FRAME_TIMEOUT, GAP_CYCLES) + 1);
  logic [1:0]         state;
  logic [TW-1:0]      timer;
  logic [FRAME_W-1:0] hold_reg;
  logic [SW-1:0]      rr_ptr;
  logic [SW-1:0]      grant;
  logic               grant_valid;
  rr_arbiter #(.N(N_SRC)) u_arb (
    .req   (src_req),
    .ptr   (rr_ptr),
    .grant (grant),
    .valid (grant_valid)
  );
  assign busy    = state != S_IDLE;
  assign tx_data = hold_reg[{tx_switch, 3'b000} +: BYTE_W];
  // every state entry clears the timer, so each branch that changes state also zeroes it
  always_ff @(posedge clk) begin
    src_ack  <= '0;
    src_done <= '0;
    src_err  <= '0;
    if (reset) begin
      state      <= S_IDLE;
      timer      <= '0;
      tx_rq      <= 1'b0;
      hold_reg   <= '0;
      active_src <= '0;
      rr_ptr     <= SW'(N_SRC - 1);
    end else begin
      case (state)
        S_IDLE: if (grant_valid) begin
          hold_reg       <= src_frame[int'(grant)*FRAME_W +: FRAME_W];
          active_src     <= grant;
          rr_ptr         <= grant;
          src_ack[grant] <= 1'b1;
          tx_rq          <= 1'b1;
          timer          <= '0;
          state          <= S_REQ;
        end
        S_REQ: if (tx_dir_rx) begin
          tx_rq <= 1'b0;
          timer <= '0;
          state <= S_BUSY;
        end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
          tx_rq               <= 1'b0;
          src_err[active_src] <= 1'b1;
          timer               <= '0;
          state               <= S_GAP;
        end else begin
          timer <= timer + 1'b1;
        end
        S_BUSY: if (!tx_dir_rx) begin
          src_done[active_src] <= 1'b1;
          timer                <= '0;
          state                <= S_GAP;
        end else if (timer == TW'(FRAME_TIMEOUT - 1)) begin
          src_err[active_src] <= 1'b1;
          timer               <= '0;
          state               <= S_GAP;
        end else begin
          timer <= timer + 1'b1;
        end
        default: if (timer == TW'(GAP_CYCLES - 1)) begin
          timer <= '0;
          state <= S_IDLE;
        end else begin
          timer <= timer + 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_frame_scheduler.sv
// tb_uart_frame_scheduler: scoreboard bench with a transmitter model driving directed scenarios
module tb_uart_frame_scheduler;
  localparam int N = 4;
  localparam int G = 16;
  typedef struct {int kind; int src; int cyc;} ev_t;
  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    src_req = '0;
  logic [64*N-1:0] src_frame = '0;
  logic [N-1:0]    src_ack, src_done, src_err;
  logic            tx_rq;
  logic [7:0]      tx_data;
  logic [2:0]      tx_switch = '0;
  logic            tx_dir_rx = 1'b0;
  logic            busy;
  logic [1:0]      active_src;
  int              checks = 0;
  int              errors = 0;
  int              cyc = 0;
  ev_t             sb[$];
  ev_t             mon_e;
  logic [N-1:0]    mon_v;
  uart_frame_scheduler #(.N_SRC(N), .GAP_CYCLES(G), .ACK_TIMEOUT(64), .FRAME_TIMEOUT(1024)) dut (
    .clk(clk), .reset(reset), .src_req(src_req), .src_frame(src_frame),
    .src_ack(src_ack), .src_done(src_done), .src_err(src_err),
    .tx_rq(tx_rq), .tx_data(tx_data), .tx_switch(tx_switch), .tx_dir_rx(tx_dir_rx),
    .busy(busy), .active_src(active_src)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void check(input string name, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, a, e, cyc);
    end
  endfunction
  function automatic void push_ev(input int k, input int s, input int c);
    sb.push_back('{k, s, c});
  endfunction
  function automatic logic [7:0] fbyte(input int s, input int k);
    return 8'(16 * s + k + 1);
  endfunction
  // kind 0 = ack, 1 = done, 2 = err
  always @(negedge clk) if (!reset) begin
    for (int k = 0; k < 3; k++) begin
      mon_v = k == 0 ? src_ack : k == 1 ? src_done : src_err;
      if (mon_v != '0) begin
        if (sb.size() == 0) check($sformatf("unexpected_ev%0d", k), 64'(mon_v), 64'd0);
        else begin
          mon_e = sb.pop_front();
          check("ev_kind", 64'(k), 64'(mon_e.kind));
          check("ev_src", 64'(mon_v), 64'(1 << mon_e.src));
          if (mon_e.cyc >= 0) check("ev_cyc", 64'(cyc), 64'(mon_e.cyc));
        end
      end
    end
  end
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin @(negedge clk); n++; end
    check("idle_wait", 64'(busy), 64'd0);
  endtask
  task automatic serve(input int src, input int dly, input int nxt, input bit clr);
    int n = 0;
    while (!tx_rq && n < 200) begin @(negedge clk); n++; end
    check("rq_wait", 64'(tx_rq), 64'd1);
    check("active_src", 64'(active_src), 64'(src));
    if (clr) src_req = '0;
    repeat (dly - 1) @(negedge clk);
    check("rq_hold", 64'(tx_rq), 64'd1);
    tx_dir_rx = 1'b1;
    @(negedge clk);
    check("rq_fall", 64'(tx_rq), 64'd0);
    for (int k = 0; k < 8; k++) begin
      tx_switch = 3'(k);
      #1;
      check($sformatf("tx_data_s%0d_b%0d", src, k), 64'(tx_data), 64'(fbyte(src, k)));
      @(negedge clk);
    end
    push_ev(1, src, cyc + 1);
    if (nxt >= 0) push_ev(0, nxt, cyc + G + 2);
    tx_dir_rx = 1'b0;
    tx_switch = '0;
    @(negedge clk);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    bit bad;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 8; k++) src_frame[64*i + 8*k +: 8] = fbyte(i, k);
    do_reset();
    check("rst_tx_rq", 64'(tx_rq), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_active", 64'(active_src), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    check("rst_pulses", 64'({src_ack, src_done, src_err}), 64'd0);
    // single frame
    src_req = 4'b0001;
    push_ev(0, 0, cyc + 1);
    @(negedge clk);
    check("grant_busy", 64'(busy), 64'd1);
    check("grant_rq", 64'(tx_rq), 64'd1);
    serve(0, 30, -1, 1'b1);
    wait_idle();
    // round-robin from a fresh pointer
    do_reset();
    src_req = 4'b1111;
    push_ev(0, 0, cyc + 1);
    serve(0, 10, 1, 1'b0);
    serve(1, 10, 2, 1'b0);
    serve(2, 10, 3, 1'b0);
    serve(3, 10, 0, 1'b0);
    serve(0, 10, -1, 1'b1);
    wait_idle();
    // ack timeout: rr_ptr is 0, only source 2 requests
    src_req = 4'b0100;
    push_ev(0, 2, cyc + 1);
    @(negedge clk);
    src_req = '0;
    push_ev(2, 2, cyc + 64);
    n = 0;
    while (tx_rq && n < 100) begin n++; @(negedge clk); end
    check("ack_to_rq_len", 64'(n), 64'd64);
    repeat (G - 1) @(negedge clk);
    check("ack_to_gap_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("ack_to_idle", 64'(busy), 64'd0);
    // frame timeout: source 3, direction stuck high
    src_req = 4'b1000;
    push_ev(0, 3, cyc + 1);
    @(negedge clk);
    src_req = '0;
    tx_dir_rx = 1'b1;
    push_ev(2, 3, cyc + 1025);
    bad = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 1024; i++) begin
      if (tx_rq !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    check("frame_to_rq_low", 64'(bad), 64'd0);
    tx_dir_rx = 1'b0;
    wait_idle();
    // frame stability: source frame overwritten after ack
    src_req = 4'b0001;
    push_ev(0, 0, cyc + 1);
    @(negedge clk);
    src_frame[63:0] = '1;
    serve(0, 5, -1, 1'b1);
    wait_idle();
    for (int k = 0; k < 8; k++) src_frame[8*k +: 8] = fbyte(0, k);
    // mid-transfer reset
    src_req = 4'b0010;
    push_ev(0, 1, cyc + 1);
    @(negedge clk);
    src_req = '0;
    tx_dir_rx = 1'b1;
    tx_switch = 3'd3;
    @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("mid_rst_tx_rq", 64'(tx_rq), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_active", 64'(active_src), 64'd0);
    check("mid_rst_tx_data", 64'(tx_data), 64'd0);
    reset = 1'b0;
    tx_dir_rx = 1'b0;
    tx_switch = '0;
    src_req = 4'b1011;
    push_ev(0, 0, cyc + 1);
    serve(0, 3, -1, 1'b1);
    wait_idle();
    @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_frame_scheduler.md
# uart_frame_scheduler

Arbiter and sequencer for the shared 8-byte RS-485 UART transmitter. Up to N_SRC requesters each offer a 64-bit frame. The block picks one round-robin, latches it, and drives the transmitter's request line. It serves the frame byte selected by the transmitter's 3-bit mux index, and tracks the transmitter's direction line to detect frame completion. It sits between the telemetry producers and the single transmitter instance on the same clock.

## Interface
- N_SRC, 4: number of requesters, 2..8.
- GAP_CYCLES, 16: idle clocks enforced between frames, ≥1.
- ACK_TIMEOUT, 64: max clocks from tx_rq rise to tx_dir_rx rise.
- FRAME_TIMEOUT, 1024: max clocks from tx_dir_rx rise to its fall.

Ports:
- clk  in  1  transmitter baud clock; single clock domain.
- reset  in  1  synchronous, active-high.
- src_req  in  N_SRC  level request per source; held until src_ack.
- src_frame  in  64*N_SRC  frame of source i at [64i+63:64i]; byte k = [64i+8k+7:64i+8k].
- src_ack  out  N_SRC  one-clock pulse: frame of that source latched.
- src_done  out  N_SRC  one-clock pulse: frame fully sent.
- src_err  out  N_SRC  one-clock pulse: frame aborted by timeout.
- tx_rq  out  1  start request to transmitter.
- tx_data  out  8  byte of latched frame indexed by tx_switch.
- tx_switch  in  3  transmitter byte-mux index.
- tx_dir_rx  in  1  transmitter RX-direction output; high for the whole transfer.
- busy  out  1  high in any state other than IDLE.
- active_src  out  clog2(N_SRC)  index of the source currently served.

## Operation
- States: IDLE, REQ, BUSY, GAP.
- **IDLE:** if src_req is non-zero, grant the first set bit searching from rr_ptr+1 upward with wrap.
  - Latch its frame into hold_reg and set active_src.
  - Pulse src_ack[grant] and update rr_ptr = grant.
  - Set tx_rq=1 and go to REQ.
- **REQ:** tx_rq held at 1 and timer counting.
  - If tx_dir_rx=1: clear tx_rq, clear timer, go to BUSY.
  - Else if timer reaches ACK_TIMEOUT-1: clear tx_rq, pulse src_err[active_src], go to GAP.
- **BUSY:** tx_rq=0.
  - If tx_dir_rx=0: pulse src_done[active_src], go to GAP.
  - Else if timer reaches FRAME_TIMEOUT-1: pulse src_err[active_src], go to GAP.
- **GAP:** count GAP_CYCLES clocks, then go to IDLE. Requests are ignored in GAP.
- tx_data is a combinational mux of hold_reg by tx_switch. It must be valid on the same clock tx_switch changes; the transmitter samples it the following clock.
- hold_reg is updated only in IDLE on grant, so frame contents are stable for the whole transfer even if src_frame changes.
- Dropping src_req after its ack has no effect on the current transfer.
- A source re-requesting during its own transfer is served only after other pending sources (round-robin).
- Timer width is clog2(max(ACK_TIMEOUT, FRAME_TIMEOUT, GAP_CYCLES)+1). The timer is cleared on every state entry.

## Timing
- Reset values: tx_rq=0, src_ack/src_done/src_err=0, busy=0, active_src=0, hold_reg=0 (so tx_data=0), rr_ptr=N_SRC-1 (source 0 wins first), state IDLE, timer 0.
- Reset asserted mid-transfer drops tx_rq on the next clock. The transmitter is reset separately; no done or err pulse is issued.
- Grant latency: src_req seen in IDLE at edge n gives src_ack pulse, tx_rq=1 and busy=1 after edge n.
- tx_rq falls the clock after tx_dir_rx is first seen high.
  - This guarantees RQ is low before the transmitter's post-transfer wait state, so it returns to its WAIT state.
- src_done is asserted the clock after tx_dir_rx is first seen low in BUSY.
- Next grant occurs no earlier than GAP_CYCLES+1 clocks after the src_done/src_err pulse.
- src_ack, src_done and src_err are mutually exclusive in time. At most one bit of each vector is set.

## Structure
- Shared package `uart_sched_pkg`: state encoding constants (IDLE=0, REQ=1, BUSY=2, GAP=3), FRAME_W=64, BYTE_W=8.
- One sub-module: `rr_arbiter` (parameter N; inputs req, ptr; outputs grant index and valid). It is purely combinational, with a priority rotate.
- The top holds the FSM, timer, hold_reg, byte mux and rr_ptr register.

## Test plan
- **Single frame:** src_req=4'b0001, frame0=64'h0807060504030201; transmitter model raises tx_dir_rx 30 clocks after tx_rq and steps tx_switch 0..7 → src_ack[0] once; tx_data = 01..08 in switch order; tx_rq falls 1 clock after dir rise; src_done[0] 1 clock after dir fall.
- **Round-robin:** src_req=4'b1111 held, frames distinct → grant order 0,1,2,3,0; each next src_ack exactly GAP_CYCLES+1 clocks after the previous src_done.
- **Ack timeout:** tx_dir_rx stuck 0 → tx_rq high exactly 64 clocks; src_err[granted] pulses; no src_done; busy falls after GAP.
- **Frame timeout:** tx_dir_rx stuck 1 → src_err after 1024 clocks in BUSY; tx_rq stays 0 throughout BUSY.
- **Frame stability:** change src_frame[0] to all-FF after src_ack[0] → tx_data still returns the original bytes.
- **Mid-transfer reset:** reset in BUSY for 1 clock → all outputs at reset values next clock; first grant after release goes to source 0.
